// File: rtl/mbinit_repairmb_ctrl_if.sv
// rtl/mbinit_repairmb_ctrl_if.sv - sideband and D2C handshake bundle for the REPAIRMB controller
interface mbinit_repairmb_ctrl_if #(
    parameter int NUM_LANES = 16
);
    logic                 i_en;
    logic [3:0]           i_rx_msg;
    logic                 i_rx_valid;
    logic                 i_sb_busy;
    logic                 i_sb_busy_fall;
    logic                 i_d2c_done;
    logic [NUM_LANES-1:0] i_d2c_result;
    logic [3:0]           o_tx_msg;
    logic                 o_tx_valid;
    logic [2:0]           o_tx_info;
    logic                 o_d2c_en;
    logic                 o_d2c_perlane;
    logic [1:0]           o_func_lanes;
    logic [2:0]           o_iter;
    logic                 o_done;
    logic                 o_error;

    modport master (
        input  i_en, i_rx_msg, i_rx_valid, i_sb_busy, i_sb_busy_fall, i_d2c_done, i_d2c_result,
        output o_tx_msg, o_tx_valid, o_tx_info, o_d2c_en, o_d2c_perlane, o_func_lanes,
               o_iter, o_done, o_error
    );

    modport slave (
        output i_en, i_rx_msg, i_rx_valid, i_sb_busy, i_sb_busy_fall, i_d2c_done, i_d2c_result,
        input  o_tx_msg, o_tx_valid, o_tx_info, o_d2c_en, o_d2c_perlane, o_func_lanes,
               o_iter, o_done, o_error
    );
endinterface

// File: rtl/mbinit_repairmb_ctrl.sv
// rtl/mbinit_repairmb_ctrl.sv - MBINIT.REPAIRMB lane-repair controller for the UCIe LTSM
// Optional response timeout is enabled by defining MBINIT_REPAIRMB_TIMEOUT_EN.
module mbinit_repairmb_ctrl #(
    parameter int NUM_LANES   = 16,
    parameter int MAX_ITER    = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    mbinit_repairmb_ctrl_if.master bus
);
    localparam int H = NUM_LANES / 2;

    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;
    localparam logic [3:0] MSG_DEG_REQ    = 4'b0101;
    localparam logic [3:0] MSG_DEG_RESP   = 4'b0110;

    typedef enum logic [3:0] {
        IDLE, START_REQ, START_WAIT, D2C_TEST, DEG_CHK, DEG_REQ, DEG_WAIT,
        END_CHK, END_REQ, END_WAIT, DONE, ERROR
    } state_t;

    state_t     state, state_d, state_prev;
    logic [1:0] applied, applied_d;
    logic [1:0] cand, cand_d, cand_c;
    logic [2:0] iter, iter_d, iter_inc;
    logic       lo, hi, in_wait, tmo_hit, handoff;

    logic [3:0] tx_msg_q;
    logic [2:0] tx_info_q;
    logic       tx_valid_q, d2c_en_q, done_q, error_q;

    assign lo       = &bus.i_d2c_result[H-1:0];
    assign hi       = &bus.i_d2c_result[NUM_LANES-1:H];
    assign iter_inc = iter + 3'd1;
    assign in_wait  = (state == START_WAIT) || (state == DEG_WAIT) || (state == END_WAIT);
    // Request states advance once the sideband has actually finished sending
    assign handoff  = bus.i_sb_busy_fall && !bus.i_sb_busy;

    always_comb begin
        cand_c = 2'b00;
        case (applied)
            2'b11:   cand_c = (lo && hi) ? 2'b11 : lo ? 2'b01 : hi ? 2'b10 : 2'b00;
            2'b01:   cand_c = lo ? 2'b01 : 2'b00;
            2'b10:   cand_c = hi ? 2'b10 : 2'b00;
            default: cand_c = 2'b00;
        endcase
    end

`ifdef MBINIT_REPAIRMB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)       tmo_cnt <= '0;
        else if (in_wait) tmo_cnt <= tmo_cnt + 1'b1;
        else              tmo_cnt <= '0;
    end

    assign tmo_hit = in_wait && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        applied_d = applied;
        cand_d    = cand;
        iter_d    = iter;
        case (state)
            IDLE:       if (!bus.i_sb_busy) state_d = START_REQ;
            START_REQ:  if (handoff) state_d = START_WAIT;
            START_WAIT: begin
                if (bus.i_rx_valid && bus.i_rx_msg == MSG_START_RESP) state_d = D2C_TEST;
                else if (tmo_hit)                                     state_d = ERROR;
            end
            D2C_TEST: begin
                if (bus.i_d2c_done) begin
                    cand_d  = cand_c;
                    state_d = DEG_CHK;
                end
            end
            DEG_CHK:    if (!bus.i_sb_busy) state_d = DEG_REQ;
            DEG_REQ:    if (handoff) state_d = DEG_WAIT;
            DEG_WAIT: begin
                if (bus.i_rx_valid && bus.i_rx_msg == MSG_DEG_RESP) begin
                    iter_d = iter_inc;
                    if (cand == 2'b00)                  state_d = ERROR;
                    else if (cand == applied)           state_d = END_CHK;
                    else if (iter_inc == 3'(MAX_ITER))  state_d = ERROR;
                    else begin
                        applied_d = cand;
                        state_d   = D2C_TEST;
                    end
                end else if (tmo_hit) begin
                    state_d = ERROR;
                end
            end
            END_CHK:    if (!bus.i_sb_busy) state_d = END_REQ;
            END_REQ:    if (handoff) state_d = END_WAIT;
            END_WAIT: begin
                if (bus.i_rx_valid && bus.i_rx_msg == MSG_END_RESP) state_d = DONE;
                else if (tmo_hit)                                   state_d = ERROR;
            end
            default: state_d = state;
        endcase
        // Abort overrides everything, including a response on the same cycle
        if (!bus.i_en) begin
            state_d   = IDLE;
            applied_d = 2'b11;
            cand_d    = 2'b00;
            iter_d    = 3'd0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            applied <= 2'b11;
            cand    <= 2'b00;
            iter    <= 3'd0;
        end else begin
            state   <= state_d;
            applied <= applied_d;
            cand    <= cand_d;
            iter    <= iter_d;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_prev <= IDLE;
            tx_valid_q <= 1'b0;
            tx_msg_q   <= 4'b0000;
            tx_info_q  <= 3'b000;
            d2c_en_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_prev <= state;
            tx_valid_q <= 1'b0;
            tx_msg_q   <= 4'b0000;
            tx_info_q  <= 3'b000;
            // One strobe per request, on the first cycle spent in the state
            if (bus.i_en && state != state_prev) begin
                case (state)
                    START_REQ: begin
                        tx_valid_q <= 1'b1;
                        tx_msg_q   <= MSG_START_REQ;
                    end
                    DEG_REQ: begin
                        tx_valid_q <= 1'b1;
                        tx_msg_q   <= MSG_DEG_REQ;
                        tx_info_q  <= {1'b0, cand};
                    end
                    END_REQ: begin
                        tx_valid_q <= 1'b1;
                        tx_msg_q   <= MSG_END_REQ;
                    end
                    default: ;
                endcase
            end
            d2c_en_q <= bus.i_en && (state == D2C_TEST) && !bus.i_d2c_done;
            done_q   <= bus.i_en && (state == DONE);
            error_q  <= bus.i_en && (state == ERROR);
        end
    end

    assign bus.o_tx_valid    = tx_valid_q;
    assign bus.o_tx_msg      = tx_msg_q;
    assign bus.o_tx_info     = tx_info_q;
    assign bus.o_d2c_en      = d2c_en_q;
    assign bus.o_d2c_perlane = d2c_en_q;
    assign bus.o_func_lanes  = applied;
    assign bus.o_iter        = iter;
    assign bus.o_done        = done_q;
    assign bus.o_error       = error_q;
endmodule
